axi_s2mm_engine: RTL and testbench
==================================

# axi_s2mm_engine

Stream-to-memory DMA engine: accepts an AXI4-Stream byte stream and writes it to a byte-addressed, possibly unaligned, memory region through an AXI4 master write port. Software programs it through an AXI4-Lite register file: destination address, byte length, start; then it polls done. It is the receive-side counterpart of the MM2S engine, sitting between an AXI4-Stream source and the BRAM/interconnect in the block design.

## Interface
- `ADDR_W`, 32: AXI4 master address width.
- `LEN_W`, 16: width of the byte-length register.
- `aclk` in 1: single clock for all interfaces.
- `aresetn` in 1: asynchronous, active-low reset.
- `s_axi_aw*`, `s_axi_w*`, `s_axi_b*`, `s_axi_ar*`, `s_axi_r*` (slave): AXI4-Lite register port, 8-bit address, 32-bit data.
- `s_axis_tdata` in 32, `s_axis_tvalid` in 1, `s_axis_tready` out 1, `s_axis_tlast` in 1: input stream. Byte 0 is `tdata[7:0]`; beats are fully packed.
- `m_axi_aw*` (AWADDR `ADDR_W`, AWLEN=0, AWSIZE=2, AWBURST=INCR), `m_axi_w*` (WDATA 32, WSTRB 4, WLAST=1), `m_axi_b*`: AXI4 master write port. Read channels are tied off.
- `irq` out 1: present only with `AXI_S2MM_IRQ_EN`.

## Operation
- Registers:
  - 0x00 CTRL: bit0 START, write-1 pulse, ignored while busy.
  - 0x04 STATUS, read-only: bit0 DONE (sticky, cleared by START), bit1 BUSY, bit2 ERR (sticky, cleared by START).
  - 0x08 IER: bit0; exists only with the macro.
  - 0x10 DST_ADDR.
  - 0x14 LEN: bytes, `LEN_W` bits.
  - 0x18 COUNT: bytes written.
- Register reads of unmapped offsets return 0. All responses are OKAY.
- FSM states:
  - IDLE: wait for START. START with LEN=0 goes directly to FINISH and issues no bus writes.
  - GATHER: assert `s_axis_tready` until the 8-byte realign buffer holds every byte the current memory word needs.
  - WRITE: drive AW and W together. Each handshake completes independently. Move to RESP once both are accepted.
  - RESP: wait for BVALID with BREADY=1. BRESP≠OKAY sets ERR and the transfer continues.
  - FINISH: set DONE, clear BUSY, return to IDLE.
- Realignment:
  - off = DST_ADDR[1:0]. First word address is DST_ADDR & ~3.
  - Words issued = ceil((off+LEN)/4).
  - WSTRB of the first word masks bytes below off. WSTRB of the last word masks bytes at or above (off+LEN) mod 4, with 0 meaning all four bytes.
  - Masked WDATA byte lanes are 0.
- Stream termination:
  - The beat containing the final byte is consumed. Its excess bytes are discarded.
  - Later beats are not accepted: tready stays 0 until the next START.
  - `tlast` before LEN bytes are received: flush the partial word with the correct WSTRB, set ERR, go to FINISH. COUNT holds the bytes actually written.
- COUNT is 32 bits wide, increments per written byte, and is cleared by START.

## Timing
- Reset values:
  - All `*valid` and `*ready` outputs are 0; `irq` is 0.
  - All registers are 0 and the FSM is in IDLE.
  - Reset asserted mid-transfer aborts immediately. No AXI handshake completion is owed.
- AXI4-Lite write: AWREADY and WREADY are asserted together for one cycle once both AWVALID and WVALID are seen. BVALID follows on the next cycle and is held until BREADY.
- AXI4-Lite read: ARREADY is a 1-cycle pulse. RVALID follows on the next cycle and is held until RREADY. STATUS reflects the state as of the cycle ARREADY pulses.
- START → BUSY=1 in the cycle after the register write handshake. `s_axis_tready` can rise the same cycle.
- Stream to bus: AWVALID and WVALID assert the cycle after the gather completes. One write is outstanding at most.
- Valid signals are never withdrawn before their ready. AW/W payloads are stable while valid.
- A START and a STATUS read in the same cycle: the read returns the pre-START value.

## Configuration
- `AXI_S2MM_IRQ_EN` defined:
  - Adds IER at 0x08 and the `irq` output.
  - irq = DONE & IER[0], registered. It falls when START clears DONE.
- `AXI_S2MM_IRQ_EN` undefined: 0x08 reads 0 and writes are ignored. There is no `irq` port.

## Test plan
- DST=0xC000_0007, LEN=6; stream 0x03020100, 0x07060504 (tlast on beat 2). Required writes:
  - 0xC000_0004 WSTRB=1000 WDATA=0x0000_0000
  - 0xC000_0008 WSTRB=1111 WDATA=0x0403_0201
  - 0xC000_000C WSTRB=0001 WDATA=0x0000_0005
  - STATUS=0x1, COUNT=6.
- Aligned DST=0xD000_0000, LEN=1024 with 256 beats (byte i = i mod 256) → 256 full-strobe writes matching bytes; DONE set, ERR=0, and at least one source tvalid stall is absorbed without data loss.
- LEN=12, tlast on beat 2 of 0x03020100/0x07060504 → 2 writes, STATUS=0x5 (DONE|ERR), COUNT=8; tready stays 0 afterward.
- LEN=0 START → STATUS=0x1 within 3 cycles, no AWVALID, no tready.
- Slave returns BRESP=SLVERR on write 2 of a 4-word transfer → all 4 writes issued, STATUS=0x5.
- aresetn pulsed low during WRITE state → all outputs 0 next edge; new START with DST=0xC000_0000, LEN=4 completes normally (macro build: irq=1 after IER=1).

Source files
------------

// File: rtl/axi_s2mm_engine.sv
// axi_s2mm_engine: stream-to-memory DMA engine.
// Takes a packed 32-bit AXI4-Stream and writes it to a byte-addressed, possibly unaligned,
// region via single-beat AXI4 writes (AWLEN=0, AWSIZE=2, INCR, WLAST=1).
// Ports:
//   aclk, aresetn      clock, async active-low reset
//   s_axi_*            AXI4-Lite register slave (8-bit address, 32-bit data)
//   s_axis_*           input byte stream, byte 0 in tdata[7:0]
//   m_axi_aw/w/b*      AXI4 write master; the master has no read channels
//   irq                DONE & IER[0], only when AXI_S2MM_IRQ_EN is defined
// Registers: 0x00 CTRL (bit0 START), 0x04 STATUS {ERR,BUSY,DONE}, 0x08 IER (AXI_S2MM_IRQ_EN),
//            0x10 DST_ADDR, 0x14 LEN, 0x18 COUNT.
module axi_s2mm_engine #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [7:0]        s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [7:0]        s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  input  logic [31:0]       s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [7:0]        m_axi_awlen,
  output logic [2:0]        m_axi_awsize,
  output logic [1:0]        m_axi_awburst,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [31:0]       m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wlast,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready
`ifdef AXI_S2MM_IRQ_EN
  ,
  output logic              irq
`endif
);

  typedef enum logic [2:0] {StIdle, StGather, StWrite, StResp, StFinish} state_e;

  state_e            state_q, state_d;
  logic [31:0]       dst_q, dst_d, count_q, count_d, waddr_q, waddr_d;
  logic [LEN_W-1:0]  len_q, len_d, rem_q, rem_d;
  logic              done_q, done_d, err_q, err_d, first_q, first_d;
  logic [1:0]        off_q, off_d;
  logic [63:0]       buf_q, buf_d;     // realign buffer, byte 0 = next memory lane 0
  logic [3:0]        bcnt_q, bcnt_d;   // bytes held in buf_q, including leading pad bytes
  logic              aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic              wrdy_q, wrdy_d, bvalid_q, bvalid_d, arrdy_q, arrdy_d, rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ier_q, ier_d;

  logic [31:0]       wmask, status, len_wr, tdata_m, wdata;
  logic [3:0]        strb;
  logic [2:0]        take_n;
  logic              start, accept;

  always_comb begin
    wmask  = {{8{s_axi_wstrb[3]}}, {8{s_axi_wstrb[2]}}, {8{s_axi_wstrb[1]}}, {8{s_axi_wstrb[0]}}};
    status = {29'b0, err_q, (state_q != StIdle), done_q};
    len_wr = (32'(len_q) & ~wmask) | (s_axi_wdata & wmask);
    start  = wrdy_q && (s_axi_awaddr == 8'h00) && s_axi_wstrb[0] && s_axi_wdata[0] &&
             (state_q == StIdle);
    // Stream bytes to keep from this beat: anything past LEN is discarded.
    take_n = (rem_q < LEN_W'(4)) ? 3'(rem_q) : 3'd4;
    for (int i = 0; i < 4; i++) begin
      tdata_m[8*i +: 8] = (3'(i) < take_n) ? s_axis_tdata[8*i +: 8] : 8'h00;
      // Lanes below the start offset in the first word hold pad bytes, never data.
      strb[i]           = (4'(i) < bcnt_q) && !(first_q && (2'(i) < off_q));
      wdata[8*i +: 8]   = strb[i] ? buf_q[8*i +: 8] : 8'h00;
    end
    s_axis_tready = (state_q == StGather) && (bcnt_q < 4'd4) && (rem_q != '0);
    accept        = s_axis_tready && s_axis_tvalid;
  end

  always_comb begin
    state_d   = state_q;
    dst_d     = dst_q;
    len_d     = len_q;
    count_d   = count_q;
    done_d    = done_q;
    err_d     = err_q;
    waddr_d   = waddr_q;
    off_d     = off_q;
    first_d   = first_q;
    buf_d     = buf_q;
    bcnt_d    = bcnt_q;
    rem_d     = rem_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    ier_d     = ier_q;

    // Register write: AW and W are accepted together, one cycle after both are seen.
    wrdy_d   = s_axi_awvalid && s_axi_wvalid && !wrdy_q && !bvalid_q;
    bvalid_d = wrdy_q ? 1'b1 : (s_axi_bready ? 1'b0 : bvalid_q);
    if (wrdy_q) begin
      case (s_axi_awaddr)
        8'h10:   dst_d = (dst_q & ~wmask) | (s_axi_wdata & wmask);
        8'h14:   len_d = len_wr[LEN_W-1:0];
`ifdef AXI_S2MM_IRQ_EN
        8'h08:   if (s_axi_wstrb[0]) ier_d = s_axi_wdata[0];
`endif
        default: ;
      endcase
    end

    // Register read: data captured in the ARREADY cycle, before any same-cycle START.
    arrdy_d  = s_axi_arvalid && !arrdy_q && !rvalid_q;
    rvalid_d = arrdy_q ? 1'b1 : (s_axi_rready ? 1'b0 : rvalid_q);
    if (arrdy_q) begin
      case (s_axi_araddr)
        8'h04:   rdata_d = status;
        8'h10:   rdata_d = dst_q;
        8'h14:   rdata_d = 32'(len_q);
        8'h18:   rdata_d = count_q;
`ifdef AXI_S2MM_IRQ_EN
        8'h08:   rdata_d = {31'b0, ier_q};
`endif
        default: rdata_d = 32'h0;
      endcase
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          done_d    = 1'b0;
          err_d     = 1'b0;
          count_d   = 32'h0;
          waddr_d   = {dst_q[31:2], 2'b00};
          off_d     = dst_q[1:0];
          first_d   = 1'b1;
          buf_d     = 64'h0;
          bcnt_d    = {2'b00, dst_q[1:0]};  // pad so stream byte 0 lands on lane off
          rem_d     = len_q;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = (len_q == '0) ? StFinish : StGather;
        end
      end
      StGather: begin
        if (accept) begin
          buf_d  = buf_q | ({32'h0, tdata_m} << {bcnt_q, 3'b000});
          bcnt_d = bcnt_q + {1'b0, take_n};
          rem_d  = rem_q - LEN_W'(take_n);
          if (s_axis_tlast && (rem_d != '0)) begin
            err_d = 1'b1;  // short stream: flush what we have and stop
            rem_d = '0;
          end
        end
        if ((bcnt_d >= 4'd4) || (rem_d == '0)) state_d = StWrite;
      end
      StWrite: begin
        if (m_axi_awready) aw_done_d = 1'b1;
        if (m_axi_wready)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = StResp;
        end
      end
      StResp: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00) err_d = 1'b1;
          count_d = count_q + 32'($countones(strb));
          buf_d   = buf_q >> 32;
          bcnt_d  = (bcnt_q >= 4'd4) ? (bcnt_q - 4'd4) : 4'd0;
          waddr_d = waddr_q + 32'd4;
          first_d = 1'b0;
          state_d = ((bcnt_d == 4'd0) && (rem_q == '0)) ? StFinish : StGather;
        end
      end
      StFinish: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= StIdle;
      dst_q     <= '0;
      len_q     <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      waddr_q   <= '0;
      off_q     <= '0;
      first_q   <= 1'b0;
      buf_q     <= '0;
      bcnt_q    <= '0;
      rem_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      wrdy_q    <= 1'b0;
      bvalid_q  <= 1'b0;
      arrdy_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      ier_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      count_q   <= count_d;
      done_q    <= done_d;
      err_q     <= err_d;
      waddr_q   <= waddr_d;
      off_q     <= off_d;
      first_q   <= first_d;
      buf_q     <= buf_d;
      bcnt_q    <= bcnt_d;
      rem_q     <= rem_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      wrdy_q    <= wrdy_d;
      bvalid_q  <= bvalid_d;
      arrdy_q   <= arrdy_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      ier_q     <= ier_d;
    end
  end

`ifdef AXI_S2MM_IRQ_EN
  logic irq_q;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) irq_q <= 1'b0;
    else          irq_q <= done_q & ier_q;
  end
  assign irq = irq_q;
`else
  logic unused_ier;
  assign unused_ier = ier_q ^ ier_d;
`endif

  assign s_axi_awready = wrdy_q;
  assign s_axi_wready  = wrdy_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_arready = arrdy_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = 2'b00;

  assign m_axi_awaddr  = ADDR_W'(waddr_q);
  assign m_axi_awlen   = 8'h00;
  assign m_axi_awsize  = 3'd2;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awvalid = (state_q == StWrite) && !aw_done_q;
  assign m_axi_wdata   = wdata;
  assign m_axi_wstrb   = strb;
  assign m_axi_wlast   = 1'b1;
  assign m_axi_wvalid  = (state_q == StWrite) && !w_done_q;
  assign m_axi_bready  = (state_q == StResp);

endmodule

// File: tb/tb_axi_s2mm_engine.sv
// Testbench for axi_s2mm_engine: scoreboard of expected memory writes (filled from a byte-level
// model when a transfer is issued), a monitor that pops and compares on each AW+W pair, a
// randomised stream source and a randomised memory slave.
module tb_axi_s2mm_engine;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [7:0]  s_axi_awaddr = '0;
  logic        s_axi_awvalid = 1'b0, s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = 4'hF;
  logic        s_axi_wvalid = 1'b0, s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid, s_axi_bready = 1'b1;
  logic [7:0]  s_axi_araddr = '0;
  logic        s_axi_arvalid = 1'b0, s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid, s_axi_rready = 1'b1;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0, s_axis_tready, s_axis_tlast = 1'b0;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awvalid, m_axi_awready = 1'b0;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready = 1'b0;
  logic [1:0]  m_axi_bresp = 2'b00;
  logic        m_axi_bvalid = 1'b0, m_axi_bready;
`ifdef AXI_S2MM_IRQ_EN
  logic        irq;
`endif

  always #5 aclk = ~aclk;

  axi_s2mm_engine #(.ADDR_W(32), .LEN_W(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
`ifdef AXI_S2MM_IRQ_EN
    , .irq(irq)
`endif
  );

  typedef struct { logic [31:0] addr; logic [3:0] strb; logic [31:0] data; } wr_t;
  typedef struct { logic [31:0] data; logic last; } beat_t;

  wr_t        exp_q[$];
  beat_t      beat_q[$];
  logic [7:0] xb[$];          // bytes of the stream for the current transfer
  int checks = 0, errors = 0;
  int wr_accepted = 0, b_issued = 0, slverr_at = 0;
  bit hold_slave = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pairs each accepted AW with its W and compares against the scoreboard.
  initial begin : monitor
    logic [31:0] a, d;
    logic [3:0]  s;
    bit ha, hw;
    wr_t e;
    ha = 0; hw = 0; a = '0; d = '0; s = '0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        ha = 0; hw = 0; exp_q.delete();
      end else begin
        if (m_axi_awvalid && m_axi_awready) begin a = m_axi_awaddr; ha = 1; end
        if (m_axi_wvalid && m_axi_wready) begin d = m_axi_wdata; s = m_axi_wstrb; hw = 1; end
        if (ha && hw) begin
          ha = 0; hw = 0; wr_accepted++;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: got addr 0x%08h strb %b data 0x%08h, expected none",
                     a, s, d);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", a, e.addr);
            check("wr_strb", 32'(s), 32'(e.strb));
            check("wr_data", d, e.data);
          end
        end
      end
    end
  end

  // Memory slave: random AWREADY/WREADY, one B per accepted write after a random delay.
  initial begin : responder
    bit bhs;
    forever begin
      @(negedge aclk);
      bhs = m_axi_bvalid && m_axi_bready;
      @(posedge aclk); #1;
      if (!aresetn) begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; b_issued = wr_accepted;
      end else begin
        m_axi_awready = !hold_slave && ($urandom_range(0, 2) != 0);
        m_axi_wready  = !hold_slave && ($urandom_range(0, 2) != 0);
        if (bhs) begin
          m_axi_bvalid = 0; b_issued++;
        end else if (!m_axi_bvalid && b_issued < wr_accepted && $urandom_range(0, 1) == 1) begin
          m_axi_bvalid = 1;
          m_axi_bresp  = (b_issued + 1 == slverr_at) ? 2'b10 : 2'b00;
        end
      end
    end
  end

  // Stream source: presents queued beats with random idle gaps, holds each until taken.
  initial begin : driver
    bit hs;
    forever begin
      @(negedge aclk);
      hs = s_axis_tvalid && s_axis_tready;
      @(posedge aclk); #1;
      if (!aresetn) begin
        beat_q.delete(); s_axis_tvalid = 0;
      end else begin
        if (hs) begin beat_q.delete(0); s_axis_tvalid = 0; end
        if (!s_axis_tvalid && beat_q.size() > 0 && $urandom_range(0, 3) != 0) begin
          s_axis_tdata  = beat_q[0].data;
          s_axis_tlast  = beat_q[0].last;
          s_axis_tvalid = 1;
        end
      end
    end
  end

  task automatic lite_write(input logic [7:0] addr, input logic [31:0] data);
    int t;
    @(posedge aclk); #1;
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1; s_axi_wvalid = 1;
    t = 0;
    do begin @(negedge aclk); t++; end while (!s_axi_awready && t < 50);
    if (!s_axi_awready) begin
      checks++; errors++; $display("FAIL lite_aw_timeout: got no AWREADY, expected one");
    end
    @(posedge aclk); #1;
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    t = 0;
    while (!s_axi_bvalid && t < 50) begin @(negedge aclk); t++; end
    check("lite_bresp", {29'b0, !s_axi_bvalid, s_axi_bresp}, 32'h0);
  endtask

  task automatic lite_read(input logic [7:0] addr, output logic [31:0] data);
    int t;
    @(posedge aclk); #1;
    s_axi_araddr = addr; s_axi_arvalid = 1;
    t = 0;
    do begin @(negedge aclk); t++; end while (!s_axi_arready && t < 50);
    @(posedge aclk); #1;
    s_axi_arvalid = 0;
    t = 0;
    while (!s_axi_rvalid && t < 50) begin @(negedge aclk); t++; end
    if (!s_axi_rvalid) begin
      checks++; errors++; $display("FAIL lite_r_timeout: got no RVALID, expected one");
    end
    data = s_axi_rdata;
  endtask

  // Reference model: memory word w, lane l carries stream byte 4w+l-off when in [0, n).
  function automatic void model_push(input logic [31:0] dst, input int n);
    int off, words, p;
    wr_t e;
    off = int'(dst[1:0]);
    words = (off + n + 3) / 4;
    for (int w = 0; w < words; w++) begin
      e.addr = {dst[31:2], 2'b00} + 32'(4 * w);
      e.strb = '0; e.data = '0;
      for (int l = 0; l < 4; l++) begin
        p = 4 * w + l - off;
        if (p >= 0 && p < n) begin e.strb[l] = 1'b1; e.data[8*l +: 8] = xb[p]; end
      end
      exp_q.push_back(e);
    end
  endfunction

  // Runs one transfer; xb holds 4*beats bytes, pre beats are already queued at the source.
  task automatic run_xfer(input string tag, input logic [31:0] dst, input int len,
                          input int beats, input int pre, input bit use_model, input int err_wr);
    int n, t;
    logic [31:0] st, cnt;
    beat_t b;
    n = (len < 4 * beats) ? len : 4 * beats;
    if (use_model) model_push(dst, n);
    for (int i = pre; i < beats; i++) begin
      b.data = {xb[4*i+3], xb[4*i+2], xb[4*i+1], xb[4*i]};
      b.last = (i == beats - 1);
      beat_q.push_back(b);
    end
    slverr_at = (err_wr != 0) ? wr_accepted + err_wr : 0;
    lite_write(8'h10, dst);
    lite_write(8'h14, 32'(len));
    lite_write(8'h00, 32'h1);
    t = 0;
    do begin lite_read(8'h04, st); t++; end while (!st[0] && t < 4000);
    lite_read(8'h04, st);
    check({tag, "_status"}, st, {29'b0, (n < len) || (err_wr != 0), 2'b01});
    lite_read(8'h18, cnt);
    check({tag, "_count"}, cnt, 32'(n));
    check({tag, "_writes_left"}, 32'(exp_q.size()), 32'h0);
    check({tag, "_beats_left"}, 32'(beat_q.size()), 32'(0));
    slverr_at = 0;
  endtask

  initial begin : main
    logic [31:0] rd, dst;
    int len, beats, bad;
    wr_t e;
    beat_t b;

    repeat (3) @(posedge aclk);
    #1;
    check("rst_outputs", {23'b0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, s_axis_tready,
          s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid}, 32'h0);
    check("aw_attrs", {18'b0, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_wlast},
          {18'b0, 8'h00, 3'd2, 2'b01, 1'b1});
    @(negedge aclk); aresetn = 1;

    lite_read(8'h04, rd); check("rst_status", rd, 32'h0);
    lite_read(8'h10, rd); check("rst_dst", rd, 32'h0);
    lite_read(8'h14, rd); check("rst_len", rd, 32'h0);
    lite_read(8'h18, rd); check("rst_count", rd, 32'h0);
    lite_read(8'h0C, rd); check("unmapped_0c", rd, 32'h0);
    lite_write(8'h08, 32'h1);
    lite_read(8'h08, rd);
`ifdef AXI_S2MM_IRQ_EN
    check("ier_rw", rd, 32'h1);
    lite_write(8'h08, 32'h0);
`else
    check("ier_absent", rd, 32'h0);
`endif

    // Unaligned 6-byte transfer with fixed expected writes.
    xb.delete();
    for (int i = 0; i < 8; i++) xb.push_back(8'(i));
    e.addr = 32'hC000_0004; e.strb = 4'b1000; e.data = 32'h0000_0000; exp_q.push_back(e);
    e.addr = 32'hC000_0008; e.strb = 4'b1111; e.data = 32'h0403_0201; exp_q.push_back(e);
    e.addr = 32'hC000_000C; e.strb = 4'b0001; e.data = 32'h0000_0005; exp_q.push_back(e);
    run_xfer("unaligned6", 32'hC000_0007, 6, 2, 0, 1'b0, 0);

    // Long aligned transfer through random source stalls.
    xb.delete();
    for (int i = 0; i < 1024; i++) xb.push_back(8'(i % 256));
    run_xfer("aligned1024", 32'hD000_0000, 1024, 256, 0, 1'b1, 0);

    // Early tlast; then a further beat must not be accepted.
    xb.delete();
    for (int i = 0; i < 8; i++) xb.push_back(8'(i));
    run_xfer("short_tlast", 32'hC000_0100, 12, 2, 0, 1'b1, 0);
    b.data = 32'h1312_1110; b.last = 1'b0;
    beat_q.push_back(b);
    bad = 0;
    repeat (20) begin @(negedge aclk); if (s_axis_tready) bad++; end
    check("no_tready_after_end", 32'(bad), 32'h0);

    // LEN=0: done immediately, no bus writes, no stream acceptance.
    lite_write(8'h14, 32'h0);
    lite_write(8'h00, 32'h1);
    bad = 0;
    repeat (4) begin @(negedge aclk); if (m_axi_awvalid || s_axis_tready) bad++; end
    check("len0_quiet", 32'(bad), 32'h0);
    lite_read(8'h04, rd); check("len0_status", rd, 32'h1);
    lite_read(8'h18, rd); check("len0_count", rd, 32'h0);
    check("len0_beat_kept", 32'(beat_q.size()), 32'h1);

    // SLVERR on write 2 of 4; first beat (0x13121110) is already waiting at the source.
    xb.delete();
    for (int i = 0; i < 16; i++) xb.push_back(8'(8'h10 + i));
    run_xfer("slverr", 32'hC000_0200, 16, 4, 1, 1'b1, 2);

    // Random transfers, one with an early tlast.
    for (int k = 0; k < 6; k++) begin
      dst = 32'hC000_1000 + 32'($urandom_range(0, 4095));
      len = (k == 3) ? $urandom_range(9, 40) : $urandom_range(1, 40);
      beats = (len + 3) / 4;
      if (k == 3) beats = beats - 1;
      xb.delete();
      for (int i = 0; i < 4 * beats; i++) xb.push_back(8'($urandom));
      run_xfer($sformatf("rand%0d", k), dst, len, beats, 0, 1'b1, 0);
    end

    // Reset while a write is pending on the bus.
    hold_slave = 1'b1;
    xb.delete();
    for (int i = 0; i < 64; i++) xb.push_back(8'($urandom));
    for (int i = 0; i < 16; i++) begin
      b.data = {xb[4*i+3], xb[4*i+2], xb[4*i+1], xb[4*i]}; b.last = (i == 15);
      beat_q.push_back(b);
    end
    lite_write(8'h10, 32'hC000_0300);
    lite_write(8'h14, 32'd64);
    lite_write(8'h00, 32'h1);
    bad = 0;
    while (!m_axi_awvalid && bad < 200) begin @(negedge aclk); bad++; end
    check("reset_reached_write", {31'b0, m_axi_awvalid}, 32'h1);
    aresetn = 0;
    #1;
    check("reset_outputs", {23'b0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, s_axis_tready,
          s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid}, 32'h0);
`ifdef AXI_S2MM_IRQ_EN
    check("reset_irq", {31'b0, irq}, 32'h0);
`endif
    repeat (2) @(negedge aclk);
    hold_slave = 1'b0;
    aresetn = 1;
    lite_read(8'h04, rd); check("post_reset_status", rd, 32'h0);
    lite_read(8'h18, rd); check("post_reset_count", rd, 32'h0);
`ifdef AXI_S2MM_IRQ_EN
    lite_write(8'h08, 32'h1);
`endif
    xb.delete();
    for (int i = 0; i < 4; i++) xb.push_back(8'($urandom));
    run_xfer("after_reset", 32'hC000_0000, 4, 1, 0, 1'b1, 0);
`ifdef AXI_S2MM_IRQ_EN
    repeat (2) @(negedge aclk);
    check("irq_after_done", {31'b0, irq}, 32'h1);
`endif

    repeat (5) @(posedge aclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
